// File: rtl/abro_stim_sequencer.sv
// -----------------------------------------------------------------------------
// abro_stim_sequencer
//
// Buffers a list of A/B stimulus steps and plays them back into an ABRO state
// machine. Each playback starts with a 2-cycle reset pulse on abro_R, then the
// buffered steps are replayed back-to-back, each held for max(hold,1) cycles.
// Playback ends with a 1-cycle done pulse. Rising edges of the observed ABRO
// output are counted while steps are being played.
//
// Ports
//   clk        : single clock, all state on rising edge
//   reset      : asynchronous, active-low; clears all state
//   cfg_valid  : step-write request
//   cfg_ready  : step-write accept (IDLE and buffer not full)
//   cfg_a/b    : A/B levels of the step being written
//   cfg_hold   : step duration in cycles (0 behaves as 1)
//   start      : begin playback (honoured in IDLE only)
//   abort      : cancel playback and flush the buffer
//   abro_A/B   : registered stimulus to the ABRO machine
//   abro_R     : registered active-high reset to the ABRO machine
//   abro_O     : ABRO output under observation
//   busy       : high while resetting or playing
//   done       : one-cycle pulse at normal completion
//   o_count    : saturating count of abro_O rising edges seen while playing
//   level      : number of buffered steps
// -----------------------------------------------------------------------------
module abro_stim_sequencer #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_a,
  input  logic                     cfg_b,
  input  logic [HOLD_W-1:0]        cfg_hold,
  input  logic                     start,
  input  logic                     abort,
  output logic                     abro_A,
  output logic                     abro_B,
  output logic                     abro_R,
  input  logic                     abro_O,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               o_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = HOLD_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Cycles still to be spent in the current step after the present one.
  function automatic logic [HOLD_W-1:0] hold_remaining(input logic [HOLD_W-1:0] h);
    logic [HOLD_W-1:0] r;
    if (h == {HOLD_W{1'b0}}) begin
      r = {HOLD_W{1'b0}};
    end else begin
      r = h - HOLD_W'(1);
    end
    return r;
  endfunction

  logic [1:0]        r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [SW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_cfg_ready;
  logic              r_abro_A;
  logic              r_abro_B;
  logic              r_abro_R;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_count;
  logic              r_prev_o;

  logic [1:0]        w_nxt_state;
  logic [HOLD_W-1:0] w_nxt_hold;
  logic              w_pop;
  logic              w_flush;
  logic              w_wr;
  logic [LW-1:0]     w_nxt_level;
  logic [SW-1:0]     w_head;
  logic              w_head_a;
  logic              w_head_b;
  logic [HOLD_W-1:0] w_head_hold;
  logic              w_rise;

  // abort discards a same-cycle write
  assign w_wr        = cfg_valid & r_cfg_ready & ~abort;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_a    = w_head[SW-1];
  assign w_head_b    = w_head[SW-2];
  assign w_head_hold = w_head[HOLD_W-1:0];
  assign w_rise      = abro_O & ~r_prev_o;
  assign w_nxt_level = w_flush ? {LW{1'b0}} : (r_level + LW'(w_wr) - LW'(w_pop));

  // Next-state, hold counter and pop decision.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_hold  = r_hold;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    if (abort) begin
      w_nxt_state = S_IDLE;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          // a write in the same cycle counts toward a non-empty buffer
          if (start && (w_wr || (r_level != {LW{1'b0}}))) begin
            w_nxt_state = S_RST;
            w_nxt_hold  = HOLD_W'(1);
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
        S_RST: begin
          if (r_hold == {HOLD_W{1'b0}}) begin
            w_nxt_state = S_PLAY;
            w_pop       = 1'b1;
            w_nxt_hold  = hold_remaining(w_head_hold);
          end else begin
            w_nxt_hold  = r_hold - HOLD_W'(1);
          end
        end
        S_PLAY: begin
          if (r_hold == {HOLD_W{1'b0}}) begin
            if (r_level != {LW{1'b0}}) begin
              w_pop      = 1'b1;
              w_nxt_hold = hold_remaining(w_head_hold);
            end else begin
              w_nxt_state = S_DONE;
            end
          end else begin
            w_nxt_hold = r_hold - HOLD_W'(1);
          end
        end
        S_DONE: begin
          w_nxt_state = S_IDLE;
        end
        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hold      <= {HOLD_W{1'b0}};
      r_abro_A    <= 1'b0;
      r_abro_B    <= 1'b0;
      r_abro_R    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_hold      <= w_nxt_hold;
      r_abro_R    <= (w_nxt_state == S_RST);
      r_busy      <= (w_nxt_state == S_RST) || (w_nxt_state == S_PLAY);
      r_done      <= (w_nxt_state == S_DONE);
      r_cfg_ready <= (w_nxt_state == S_IDLE) && (w_nxt_level < LW'(DEPTH));
      if (w_pop) begin
        r_abro_A <= w_head_a;
        r_abro_B <= w_head_b;
      end else if (w_nxt_state != S_PLAY) begin
        r_abro_A <= 1'b0;
        r_abro_B <= 1'b0;
      end else begin
        r_abro_A <= r_abro_A;
        r_abro_B <= r_abro_B;
      end
    end
  end

  // Step FIFO: storage, pointers (wrap modulo DEPTH) and fill level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {SW{1'b0}};
      end
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      r_level <= w_nxt_level;
      if (w_flush) begin
        r_wr_ptr <= {PW{1'b0}};
        r_rd_ptr <= {PW{1'b0}};
      end else begin
        if (w_wr) begin
          r_mem[r_wr_ptr] <= {cfg_a, cfg_b, cfg_hold};
          r_wr_ptr        <= r_wr_ptr + PW'(1);
        end else begin
          r_wr_ptr <= r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end else begin
          r_rd_ptr <= r_rd_ptr;
        end
      end
    end
  end

  // Rising-edge counter on abro_O: cleared on entry to RST, counts in PLAY only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= 8'd0;
      r_prev_o <= 1'b0;
    end else begin
      r_prev_o <= abro_O;
      if ((r_state == S_IDLE) && (w_nxt_state == S_RST)) begin
        r_count <= 8'd0;
      end else if ((r_state == S_PLAY) && w_rise && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign abro_A    = r_abro_A;
  assign abro_B    = r_abro_B;
  assign abro_R    = r_abro_R;
  assign busy      = r_busy;
  assign done      = r_done;
  assign o_count   = r_count;
  assign level     = r_level;

endmodule
